// File: rtl/cond_unit.sv
// ARMv4 condition-check unit: holds the architectural NZCV flag register and
// gates the control unit's PC/register/memory write enables on the condition field.
module cond_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic [1:0] i_flag_w,
    input  logic       i_pcs,
    input  logic       i_reg_w,
    input  logic       i_mem_w,
    input  logic       i_no_write,
    output logic [3:0] o_flags,
    output logic       o_cond_ex,
    output logic       o_pc_src,
    output logic       o_reg_write,
    output logic       o_mem_write
);

    logic [3:0] r_flags;
    logic       w_n, w_z, w_c, w_v;
    logic       w_cond_ex;

    assign w_n = r_flags[0];
    assign w_z = r_flags[1];
    assign w_c = r_flags[2];
    assign w_v = r_flags[3];

    // Decode uses only the registered flags so a flag-setting instruction
    // never feeds its own condition through alu_flags.
    always_comb begin
        w_cond_ex = 1'b0;
        case (i_cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            4'b1111: w_cond_ex = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_flags <= RESET_FLAGS;
        end else begin
            if (i_flag_w[1] && w_cond_ex) begin
                r_flags[1:0] <= i_alu_flags[1:0];
            end
            if (i_flag_w[0] && w_cond_ex) begin
                r_flags[3:2] <= i_alu_flags[3:2];
            end
        end
    end

    assign o_flags     = r_flags;
    assign o_cond_ex   = w_cond_ex;
    assign o_pc_src    = i_pcs & w_cond_ex;
    assign o_reg_write = i_reg_w & w_cond_ex & ~i_no_write;
    assign o_mem_write = i_mem_w & w_cond_ex;

endmodule

// File: doc/cond_unit.md
# cond_unit

Condition-check and status-flag register for the ARMv4 datapath. It consumes the 4-bit NZCV flag vector produced by the ALU adder and latches it into the processor's architectural flag register under instruction control. It evaluates the instruction's condition field against the latched flags and gates the control unit's write and branch enables.

## Interface

- RESET_FLAGS, 4'b0000: flag register value after reset, bit order as for `alu_flags`.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- cond  in  4  instruction condition field, instr[31:28]
- alu_flags  in  4  ALU flags: bit0=N, bit1=Z, bit2=C, bit3=V
- flag_w  in  2  flag write request: bit1 updates N,Z (bits 1:0); bit0 updates C,V (bits 3:2)
- pcs  in  1  control unit requests PC write (branch or write to R15)
- reg_w  in  1  control unit requests register-file write
- mem_w  in  1  control unit requests data-memory write
- no_write  in  1  suppresses register write for compare/test ops (CMP, CMN, TST, TEQ)
- flags  out  4  architectural flag register, same bit order as `alu_flags`
- cond_ex  out  1  condition passes against `flags`
- pc_src  out  1  `pcs & cond_ex`
- reg_write  out  1  `reg_w & cond_ex & ~no_write`
- mem_write  out  1  `mem_w & cond_ex`

## Operation

- Flag register: two independent 2-bit fields, NZ = flags[1:0] and CV = flags[3:2].
- At each rising edge:
  - if `reset`, flags <= RESET_FLAGS;
  - otherwise NZ <= alu_flags[1:0] when `flag_w[1] & cond_ex`, and CV <= alu_flags[3:2] when `flag_w[0] & cond_ex`.
  - A field that is not written holds its value.
- `cond_ex` is combinational from `cond` and the registered `flags`. It never uses `alu_flags` directly: an instruction is conditioned on the flags left by earlier instructions.
- Condition decode (n, z, c, v = flags[0..3]):
  - 0000 EQ: z; 0001 NE: !z
  - 0010 CS: c; 0011 CC: !c
  - 0100 MI: n; 0101 PL: !n
  - 0110 VS: v; 0111 VC: !v
  - 1000 HI: c & !z; 1001 LS: !c | z
  - 1010 GE: n == v; 1011 LT: n != v
  - 1100 GT: !z & (n == v); 1101 LE: z | (n != v)
  - 1110 AL: 1; 1111: 1 (treated as always)
- A failed condition suppresses all side effects of the instruction: no flag update, no PC write, no register write, no memory write.
- Gated outputs are purely combinational from the inputs and the current `flags`. No output latency is added.

## Timing

- Single clock domain. The only state is the 4-bit flag register.
- Flag update latency: 1 cycle. Flags written at edge k are visible on `flags`/`cond_ex` immediately after edge k.
- Same-cycle dependency: an instruction that sets flags and a following instruction that tests them evaluate correctly on consecutive cycles, with no bubble.
- Reset: sampled at the edge. During the reset cycle the outputs still reflect the current (pre-reset) `flags` combinationally. After the edge, `flags` = RESET_FLAGS, so with default reset EQ=0, NE=1, AL=1.
- Reset overrides any flag write in the same cycle.
- `flag_w = 2'b11` with `cond_ex = 0`: flags unchanged.
- `flag_w` set while `cond` evaluates on the old flags: the condition uses the pre-edge flags, and the update happens at the edge (no combinational loop through `alu_flags`).
- Partial write (`flag_w = 2'b10`, logical ops): C,V preserved exactly.

## Test plan

- Reset: assert `reset` for 1 edge with `alu_flags` = 4'b1111 and `flag_w` = 2'b11 -> `flags` = 4'b0000; `cond` = 0000 gives `cond_ex` = 0; `cond` = 0001 gives `cond_ex` = 1.
- Full update and EQ: `cond` = 1110, `flag_w` = 11, `alu_flags` = 4'b0110 (Z=1, C=1), one edge -> `flags` = 0110. Next cycle, `cond` = 0000, `reg_w` = 1 -> `reg_write` = 1. `cond` = 1000 (HI) -> `cond_ex` = 0.
- Partial update: from `flags` = 4'b1100, `flag_w` = 10, `alu_flags` = 4'b0001, AL, one edge -> `flags` = 1101.
- Suppression: `flags` = 0000, `cond` = 0000, `flag_w` = 11, `pcs` = `reg_w` = `mem_w` = 1, `alu_flags` = 1111 -> `pc_src` = `reg_write` = `mem_write` = 0; after the edge `flags` still 0000.
- Compare op: AL, `reg_w` = 1, `no_write` = 1, `flag_w` = 11, `alu_flags` = 4'b1001 (N=1, V=1) -> `reg_write` = 0. After the edge: `cond` = 1010 (GE) gives 1, 1011 (LT) gives 0, 1100 (GT) gives 1.
- Exhaustive: all 16 flag values × 16 `cond` values checked against the decode list above; `cond` = 1111 always 1.
